// File: rtl/tx_serial_param.sv
// Parametrised parallel-to-serial transmitter with valid/ready word intake and end-of-frame pulse.
// Optional even-parity bit after the data bits when TX_SERIAL_PARITY_EN is defined.
//
// state | meaning
// IDLE  | ready for a word, line quiet
// SHIFT | data bits on data_o, each held CLKS_PER_BIT cycles
// PAR   | even-parity bit on data_o (parity build only)
// DONE  | one-cycle end-of-frame pulse
module tx_serial_param #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int MSB_FIRST    = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              data_o,
  output logic              ena_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_MAX = CNT_W'(DATA_W - 1);

`ifdef TX_SERIAL_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd3} state_t;
`endif

  state_t            st_q, st_d;
  logic [DATA_W-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              ready_q, ready_d;
  logic              data_q, data_d;
  logic              ena_q, ena_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              div_wrap;
`ifdef TX_SERIAL_PARITY_EN
  logic              par_q, par_d;
`endif

  assign div_wrap = (div_q == DIV_MAX);

  always_comb begin
    st_d      = st_q;
    sreg_d    = sreg_q;
    bit_cnt_d = bit_cnt_q;
    div_d     = div_q;
`ifdef TX_SERIAL_PARITY_EN
    par_d     = par_q;
`endif
    case (st_q)
      IDLE: begin
        if (valid_i) begin
          sreg_d    = data_i;
          bit_cnt_d = '0;
          div_d     = '0;
`ifdef TX_SERIAL_PARITY_EN
          par_d     = ^data_i;
`endif
          st_d      = SHIFT;
        end
      end
      SHIFT: begin
        if (div_wrap) begin
          div_d     = '0;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          sreg_d    = (MSB_FIRST != 0) ? {sreg_q[DATA_W-2:0], 1'b0}
                                       : {1'b0, sreg_q[DATA_W-1:1]};
          if (bit_cnt_q == BIT_MAX) begin
`ifdef TX_SERIAL_PARITY_EN
            st_d = PAR;
`else
            st_d = DONE;
`endif
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
`ifdef TX_SERIAL_PARITY_EN
      PAR: begin
        if (div_wrap) begin
          div_d = '0;
          st_d  = DONE;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
`endif
      DONE:    st_d = IDLE;
      default: st_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they leave the flops aligned with it.
    ready_d = (st_d == IDLE);
    busy_d  = (st_d != IDLE);
    done_d  = (st_d == DONE);
    ena_d   = (st_d == SHIFT);
    data_d  = 1'b0;
    if (st_d == SHIFT)
      data_d = (MSB_FIRST != 0) ? sreg_d[DATA_W-1] : sreg_d[0];
`ifdef TX_SERIAL_PARITY_EN
    if (st_d == PAR) begin
      ena_d  = 1'b1;
      data_d = par_d;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q      <= IDLE;
      sreg_q    <= '0;
      bit_cnt_q <= '0;
      div_q     <= '0;
      ready_q   <= 1'b1;
      data_q    <= 1'b0;
      ena_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef TX_SERIAL_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      st_q      <= st_d;
      sreg_q    <= sreg_d;
      bit_cnt_q <= bit_cnt_d;
      div_q     <= div_d;
      ready_q   <= ready_d;
      data_q    <= data_d;
      ena_q     <= ena_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef TX_SERIAL_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign ready_o = ready_q;
  assign data_o  = data_q;
  assign ena_o   = ena_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_tx_serial_param.sv
// Directed bench for tx_serial_param: MSB-first/4-clock and LSB-first/1-clock instances.
// Expectations follow TX_SERIAL_PARITY_EN when the bench is compiled with it.
module tb_tx_serial_param;

  logic       clk;
  logic       rst_n;
  logic [7:0] din [2];
  logic [1:0] valid;
  logic [1:0] ready, dout, ena, busy, done;

  int n_assert = 0;
  int n_fail   = 0;

  tx_serial_param #(.DATA_W(8), .CLKS_PER_BIT(4), .MSB_FIRST(1)) u_msb (
    .clk_i(clk), .rst_ni(rst_n), .data_i(din[0]), .valid_i(valid[0]),
    .ready_o(ready[0]), .data_o(dout[0]), .ena_o(ena[0]), .busy_o(busy[0]), .done_o(done[0])
  );

  tx_serial_param #(.DATA_W(8), .CLKS_PER_BIT(1), .MSB_FIRST(0)) u_lsb (
    .clk_i(clk), .rst_ni(rst_n), .data_i(din[1]), .valid_i(valid[1]),
    .ready_o(ready[1]), .data_o(dout[1]), .ena_o(ena[1]), .busy_o(busy[1]), .done_o(done[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input int s);
    chk("idle_ready", 32'(ready[s]), 1);
    chk("idle_ena",   32'(ena[s]),   0);
    chk("idle_data",  32'(dout[s]),  0);
    chk("idle_busy",  32'(busy[s]),  0);
    chk("idle_done",  32'(done[s]),  0);
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the IDLE cycle after DONE.
  task automatic frame(input int s, input logic [7:0] w, input int cpb, input bit msb,
                       input logic [7:0] nxt, input bit keep);
    logic exp_bit;
    din[s]   = w;
    valid[s] = 1'b1;
    chk("ready_before", 32'(ready[s]), 1);
    @(negedge clk);
    din[s]   = nxt;
    valid[s] = keep;
    for (int i = 0; i < 8; i++) begin
      exp_bit = msb ? w[7-i] : w[i];
      for (int c = 0; c < cpb; c++) begin
        chk($sformatf("data_bit%0d_c%0d", i, c), 32'(dout[s]), 32'(exp_bit));
        chk("ena_bit", 32'(ena[s]), 1);
        chk("busy_bit", 32'(busy[s]), 1);
        chk("ready_bit", 32'(ready[s]), 0);
        @(negedge clk);
      end
    end
`ifdef TX_SERIAL_PARITY_EN
    for (int c = 0; c < cpb; c++) begin
      chk("par_data", 32'(dout[s]), 32'(^w));
      chk("par_ena", 32'(ena[s]), 1);
      @(negedge clk);
    end
`endif
    chk("done_pulse", 32'(done[s]),  1);
    chk("done_ena",   32'(ena[s]),   0);
    chk("done_data",  32'(dout[s]),  0);
    chk("done_ready", 32'(ready[s]), 0);
    chk("done_busy",  32'(busy[s]),  1);
    @(negedge clk);
    chk("after_ready", 32'(ready[s]), 1);
    chk("after_done",  32'(done[s]),  0);
    chk("after_busy",  32'(busy[s]),  0);
    chk("after_ena",   32'(ena[s]),   0);
  endtask

  initial begin
    rst_n  = 1'b0;
    valid  = 2'b00;
    din[0] = 8'h00;
    din[1] = 8'h00;
    repeat (3) @(negedge clk);
    check_idle(0);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle(0);
    check_idle(1);

    frame(0, 8'hC1, 4, 1'b1, 8'h00, 1'b0);
    @(negedge clk);
    frame(1, 8'hC1, 1, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    frame(0, 8'hC3, 4, 1'b1, 8'h00, 1'b0);
    frame(1, 8'h96, 1, 1'b0, 8'h00, 1'b0);

    // valid_i held with 0xFF through a 0xC1 frame; 0xFF must follow after a 2-cycle gap
    frame(0, 8'hC1, 4, 1'b1, 8'hFF, 1'b1);
    frame(0, 8'hFF, 4, 1'b1, 8'h00, 1'b0);

    // Abort 0x1F (bit 3 is a 1) in the middle of bit 3
    din[0]   = 8'h1F;
    valid[0] = 1'b1;
    @(negedge clk);
    valid[0] = 1'b0;
    repeat (13) @(negedge clk);
    chk("pre_rst_ena",  32'(ena[0]),  1);
    chk("pre_rst_data", 32'(dout[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    check_idle(0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_done", 32'(done[0]), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_idle(0);
    frame(0, 8'h5A, 4, 1'b1, 8'h00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_serial_param.md
# tx_serial_param

Parametrised parallel-to-serial transmitter; next generation of the team's simple serial TX. Accepts a DATA_W-bit word through a valid/ready handshake and shifts it out one bit at a time. Each bit is held for CLKS_PER_BIT clock cycles, and the bit order is selectable. An end-of-frame pulse is produced after the last bit. Sits between a word source (register block or FIFO) and a single-wire serial link, with ena_o qualifying each transmitted bit.

## Interface
- DATA_W, 8, word width in bits; legal range ≥ 2.
- CLKS_PER_BIT, 4, clock cycles each bit is held on data_o; legal range ≥ 1.
- MSB_FIRST, 1, bit order: 1 sends bit DATA_W-1 first, 0 sends bit 0 first.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  reset; asynchronous, active-low.
- data_i  input  DATA_W  word to transmit; sampled only on handshake.
- valid_i  input  1  data_i valid.
- ready_o  output  1  block idle and able to accept a word.
- data_o  output  1  serial bit.
- ena_o  output  1  high while data_o carries a frame bit.
- busy_o  output  1  frame in progress, including the DONE cycle.
- done_o  output  1  one-cycle end-of-frame pulse.

## Operation
- FSM states: IDLE, SHIFT, PAR (exists only with the parity macro), DONE.
- IDLE:
  - ready_o=1, ena_o=0, data_o=0, busy_o=0.
  - valid_i=1 at a rising edge is a handshake: load data_i into the shift register, clear the bit counter and the clock-divider counter, then go to SHIFT.
- SHIFT:
  - data_o is the current head bit of the shift register: MSB when MSB_FIRST=1, LSB otherwise. ena_o=1.
  - The divider counts 0..CLKS_PER_BIT-1. On wrap it shifts the register, increments the bit counter and restarts.
  - On the wrap of bit DATA_W-1, go to PAR if compiled in, otherwise to DONE.
- PAR: data_o is the parity bit and ena_o=1 for CLKS_PER_BIT cycles, then go to DONE.
- DONE: done_o=1, ena_o=0, data_o=0, ready_o=0, busy_o=1 for exactly one cycle, then go to IDLE.
- ready_o is 1 only in IDLE. valid_i outside IDLE is ignored, and data_i changes outside IDLE have no effect.
- Counter widths: bit counter $clog2(DATA_W+1); divider max($clog2(CLKS_PER_BIT),1). With CLKS_PER_BIT=1 the divider wraps every cycle.
- Reset value of every output: ready_o=1, data_o=0, ena_o=0, busy_o=0, done_o=0. State goes to IDLE and the registers clear.
- Reset asserted mid-frame aborts the frame immediately (asynchronous): no done_o pulse, and the partial word is discarded.

## Timing
- Handshake at edge k: the first bit appears on data_o with ena_o=1 in the cycle after edge k.
- Frame length: N = DATA_W×CLKS_PER_BIT cycles with ena_o=1, plus CLKS_PER_BIT more if parity is enabled.
- done_o is high in the cycle immediately after the last ena_o=1 cycle.
- ready_o returns to 1 one cycle after done_o, so the earliest next handshake is at the edge ending that cycle.
- Back-to-back words: ena_o gap of exactly 2 cycles between frames (the DONE cycle plus the IDLE handshake cycle).
- data_o, ena_o, done_o, ready_o and busy_o are all registered-state decodes: no combinational path from valid_i or data_i to any output.

## Configuration
- TX_SERIAL_PARITY_EN defined:
  - PAR state is present.
  - The even-parity bit (XOR of the loaded word) is sent after the data bits for CLKS_PER_BIT cycles with ena_o=1.
  - Frame length becomes (DATA_W+1)×CLKS_PER_BIT.
- TX_SERIAL_PARITY_EN undefined: no PAR state and no parity logic; the frame is data bits only.

## Test plan
- Reset, then idle: after releasing rst_ni, check ready_o=1, ena_o=0, data_o=0, done_o=0.
- MSB-first frame: DATA_W=8, CLKS_PER_BIT=4, MSB_FIRST=1, send 0xC1.
  - data_o = 1,1,0,0,0,0,0,1, each bit held 4 cycles; ena_o high for 32 cycles.
  - done_o pulses in the 33rd cycle after the handshake; ready_o=1 in the 34th.
- LSB-first frame: MSB_FIRST=0, CLKS_PER_BIT=1, send 0xC1.
  - data_o = 1,0,0,0,0,0,1,1 on consecutive cycles; ena_o high for 8 cycles.
- Parity build: with TX_SERIAL_PARITY_EN, send 0xC1 → a 9th bit of 1 (three ones), ena_o high for 36 cycles.
  - Send 0xC3 → 9th bit 0.
- Handshake protection: hold valid_i=1 with data_i=0xFF throughout a 0xC1 frame.
  - Transmitted bits match 0xC1 only.
  - The next frame (0xFF) starts exactly 2 cycles after ena_o falls.
- Reset mid-frame: assert rst_ni=0 during bit 3.
  - All outputs reach reset values without waiting for a clock edge; no done_o pulse.
  - After release, a new 0x5A frame transmits correctly.
